// File: rtl/scope_cmd_parser.sv
// ---------------------------------------------------------------------------
// scope_cmd_parser
//
// Turns the byte stream from the UART receiver into scope control: arm/stop
// strobes, a trigger configuration (edge, 40-bit value, 40-bit mask) and
// status replies on the UART transmit byte interface.
//
// Ports
//    clk          in   system clock
//    rst_n        in   asynchronous active-low reset
//    rx_data      in   received byte, valid with rx_valid
//    rx_valid     in   one-cycle strobe per received byte
//    tx_data      out  reply byte, stable while tx_valid is high
//    tx_valid     out  reply byte valid, held until tx_ready
//    tx_ready     in   transmitter accepts byte when tx_valid & tx_ready
//    scope_armed  in   armed status from the capture unit
//    arm_pulse    out  one-cycle strobe: arm scope
//    stop_pulse   out  one-cycle strobe: disarm scope
//    trig_edge    out  1 = rising, 0 = falling
//    trig_value   out  trigger compare value
//    trig_mask    out  trigger compare mask (1 = bit participates)
//    cfg_valid    out  one-cycle strobe when trig_* change
//    err_pulse    out  one-cycle strobe: unknown opcode, timeout, dropped byte
//
// Optional feature macro: SCOPE_CMD_ECHO_EN
//    When defined, every completed A/S/R/F command is acknowledged by sending
//    its opcode byte back through the reply handshake.
// ---------------------------------------------------------------------------
module scope_cmd_parser #(
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int TIMEOUT_W      = 17
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic        scope_armed,
   output logic        arm_pulse,
   output logic        stop_pulse,
   output logic        trig_edge,
   output logic [39:0] trig_value,
   output logic [39:0] trig_mask,
   output logic        cfg_valid,
   output logic        err_pulse
);

   typedef enum logic [1:0] {
      IDLE,
      PAYLOAD,
      COMMIT,
      REPLY
   } state_t;

   localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   state_t               state_q, state_d;
   logic                 edgeShadow_q, edgeShadow_d;
   logic [39:0]          valueShadow_q, valueShadow_d;
   logic [39:0]          maskShadow_q, maskShadow_d;
   logic [3:0]           byteCnt_q, byteCnt_d;
   logic [TIMEOUT_W-1:0] timeoutCnt_q, timeoutCnt_d;
   logic                 trigEdge_q, trigEdge_d;
   logic [39:0]          trigValue_q, trigValue_d;
   logic [39:0]          trigMask_q, trigMask_d;
   logic                 cfgLoaded_q, cfgLoaded_d;
   logic [7:0]           txData_q, txData_d;
   logic                 armPulse_q, armPulse_d;
   logic                 stopPulse_q, stopPulse_d;
   logic                 cfgValid_q, cfgValid_d;
   logic                 errPulse_q, errPulse_d;

   // Next-state and datapath decode. Payload bytes are shifted in from the
   // top so that after five bytes the first (least significant) byte sits in
   // bits [7:0]. On the tenth byte the live trigger registers are loaded in
   // one step from the shadows plus the incoming byte, so the new config and
   // cfg_valid both appear during the COMMIT cycle and never partially.
   always_comb begin
      state_d       = state_q;
      edgeShadow_d  = edgeShadow_q;
      valueShadow_d = valueShadow_q;
      maskShadow_d  = maskShadow_q;
      byteCnt_d     = byteCnt_q;
      timeoutCnt_d  = timeoutCnt_q;
      trigEdge_d    = trigEdge_q;
      trigValue_d   = trigValue_q;
      trigMask_d    = trigMask_q;
      cfgLoaded_d   = cfgLoaded_q;
      txData_d      = txData_q;
      armPulse_d    = 1'b0;
      stopPulse_d   = 1'b0;
      cfgValid_d    = 1'b0;
      errPulse_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (rx_valid) begin
               case (rx_data)
                  8'h41: begin
                     armPulse_d = 1'b1;
`ifdef SCOPE_CMD_ECHO_EN
                     txData_d   = rx_data;
                     state_d    = REPLY;
`endif
                  end
                  8'h53: begin
                     stopPulse_d = 1'b1;
`ifdef SCOPE_CMD_ECHO_EN
                     txData_d    = rx_data;
                     state_d     = REPLY;
`endif
                  end
                  8'h52, 8'h46: begin
                     edgeShadow_d = (rx_data == 8'h52);
                     byteCnt_d    = 4'd0;
                     timeoutCnt_d = '0;
                     txData_d     = rx_data;
                     state_d      = PAYLOAD;
                  end
                  8'h3F: begin
                     txData_d = {5'b0, trigEdge_q, scope_armed, cfgLoaded_q};
                     state_d  = REPLY;
                  end
                  default: begin
                     errPulse_d = 1'b1;
                  end
               endcase
            end
         end

         PAYLOAD: begin
            if (rx_valid) begin
               timeoutCnt_d = '0;
               byteCnt_d    = byteCnt_q + 4'd1;
               if (byteCnt_q < 4'd5) begin
                  valueShadow_d = {rx_data, valueShadow_q[39:8]};
               end else begin
                  maskShadow_d = {rx_data, maskShadow_q[39:8]};
               end
               if (byteCnt_q == 4'd9) begin
                  trigEdge_d  = edgeShadow_q;
                  trigValue_d = valueShadow_q;
                  trigMask_d  = {rx_data, maskShadow_q[39:8]};
                  cfgValid_d  = 1'b1;
                  cfgLoaded_d = 1'b1;
                  state_d     = COMMIT;
               end
            end else if (timeoutCnt_q == TIMEOUT_LAST) begin
               errPulse_d    = 1'b1;
               valueShadow_d = '0;
               maskShadow_d  = '0;
               state_d       = IDLE;
            end else begin
               timeoutCnt_d = timeoutCnt_q + 1'b1;
            end
         end

         COMMIT: begin
            errPulse_d = rx_valid;
`ifdef SCOPE_CMD_ECHO_EN
            state_d    = REPLY;
`else
            state_d    = IDLE;
`endif
         end

         REPLY: begin
            errPulse_d = rx_valid;
            if (tx_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset puts the trigger back to its
   // power-up config (rising edge, zero value and mask) and discards any
   // half-received payload.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         edgeShadow_q  <= 1'b1;
         valueShadow_q <= '0;
         maskShadow_q  <= '0;
         byteCnt_q     <= 4'd0;
         timeoutCnt_q  <= '0;
         trigEdge_q    <= 1'b1;
         trigValue_q   <= '0;
         trigMask_q    <= '0;
         cfgLoaded_q   <= 1'b0;
         txData_q      <= 8'h00;
         armPulse_q    <= 1'b0;
         stopPulse_q   <= 1'b0;
         cfgValid_q    <= 1'b0;
         errPulse_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         edgeShadow_q  <= edgeShadow_d;
         valueShadow_q <= valueShadow_d;
         maskShadow_q  <= maskShadow_d;
         byteCnt_q     <= byteCnt_d;
         timeoutCnt_q  <= timeoutCnt_d;
         trigEdge_q    <= trigEdge_d;
         trigValue_q   <= trigValue_d;
         trigMask_q    <= trigMask_d;
         cfgLoaded_q   <= cfgLoaded_d;
         txData_q      <= txData_d;
         armPulse_q    <= armPulse_d;
         stopPulse_q   <= stopPulse_d;
         cfgValid_q    <= cfgValid_d;
         errPulse_q    <= errPulse_d;
      end
   end

   // Outputs come straight from registers, so strobes are glitch-free and
   // tx_data cannot move while tx_valid is waiting for tx_ready.
   assign tx_data    = txData_q;
   assign tx_valid   = (state_q == REPLY);
   assign arm_pulse  = armPulse_q;
   assign stop_pulse = stopPulse_q;
   assign trig_edge  = trigEdge_q;
   assign trig_value = trigValue_q;
   assign trig_mask  = trigMask_q;
   assign cfg_valid  = cfgValid_q;
   assign err_pulse  = errPulse_q;

endmodule

// File: tb/tb_scope_cmd_parser.sv
// ---------------------------------------------------------------------------
// tb_scope_cmd_parser
//
// Directed bench for scope_cmd_parser with a short inter-byte timeout.
// Bytes are driven on the falling edge; outputs are checked on the falling
// edge, and strobe/handshake occurrences are counted on the rising edge.
// ---------------------------------------------------------------------------
module tb_scope_cmd_parser;

   logic        clk;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        scope_armed;
   logic        arm_pulse;
   logic        stop_pulse;
   logic        trig_edge;
   logic [39:0] trig_value;
   logic [39:0] trig_mask;
   logic        cfg_valid;
   logic        err_pulse;

   int vectors     = 0;
   int miscompares = 0;
   int armCount    = 0;
   int stopCount   = 0;
   int cfgCount    = 0;
   int errCount    = 0;
   int txCount     = 0;

   int armSnap, stopSnap, cfgSnap, errSnap, txSnap;

   scope_cmd_parser #(
      .TIMEOUT_CYCLES(50),
      .TIMEOUT_W(17)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .scope_armed(scope_armed),
      .arm_pulse(arm_pulse),
      .stop_pulse(stop_pulse),
      .trig_edge(trig_edge),
      .trig_value(trig_value),
      .trig_mask(trig_mask),
      .cfg_valid(cfg_valid),
      .err_pulse(err_pulse)
   );

   // 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count strobe cycles and completed tx handshakes at the sampling edge
   always @(posedge clk) begin
      if (arm_pulse)            armCount++;
      if (stop_pulse)           stopCount++;
      if (cfg_valid)            cfgCount++;
      if (err_pulse)            errCount++;
      if (tx_valid && tx_ready) txCount++;
   end

   // Compare one observed value with its expected value and report mismatches
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Present one byte for one clock; returns on the falling edge after the
   // byte was sampled, i.e. in the cycle where strobes must be visible
   task automatic applyStimulus(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   // Acknowledge echo: with the echo feature the opcode must be offered on
   // tx and is accepted here; without it, tx must stay quiet
   task automatic finishEcho(input logic [7:0] op);
`ifdef SCOPE_CMD_ECHO_EN
      checkOutput("echo_valid", {63'b0, tx_valid}, 64'd1);
      checkOutput("echo_data", {56'b0, tx_data}, {56'b0, op});
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      checkOutput("echo_done", {63'b0, tx_valid}, 64'd0);
`else
      checkOutput("no_echo", {63'b0, tx_valid}, 64'd0);
      checkOutput("no_echo_op", {56'b0, op}, {56'b0, op ^ {7'b0, tx_valid}});
`endif
   endtask

   task automatic snapCounts();
      armSnap  = armCount;
      stopSnap = stopCount;
      cfgSnap  = cfgCount;
      errSnap  = errCount;
      txSnap   = txCount;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_arm"},   {63'b0, arm_pulse},  64'd0);
      checkOutput({tag, "_stop"},  {63'b0, stop_pulse}, 64'd0);
      checkOutput({tag, "_cfg"},   {63'b0, cfg_valid},  64'd0);
      checkOutput({tag, "_err"},   {63'b0, err_pulse},  64'd0);
      checkOutput({tag, "_txv"},   {63'b0, tx_valid},   64'd0);
      checkOutput({tag, "_txd"},   {56'b0, tx_data},    64'd0);
      checkOutput({tag, "_edge"},  {63'b0, trig_edge},  64'd1);
      checkOutput({tag, "_value"}, {24'b0, trig_value}, 64'd0);
      checkOutput({tag, "_mask"},  {24'b0, trig_mask},  64'd0);
   endtask

   logic [7:0] rCmd   [11] = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                8'h00, 8'h00, 8'h00, 8'h40, 8'h00};
   logic [7:0] fSlow  [11] = '{8'h46, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                                8'hFF, 8'h00, 8'hFF, 8'h00, 8'h0F};
   logic [7:0] rFresh [11] = '{8'h52, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE,
                                8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

   initial begin
      rst_n       = 1'b0;
      rx_data     = 8'h00;
      rx_valid    = 1'b0;
      tx_ready    = 1'b0;
      scope_armed = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      checkResetOutputs("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Arm: exactly one cycle, one clock after the byte
      snapCounts();
      applyStimulus(8'h41);
      checkOutput("arm_high", {63'b0, arm_pulse}, 64'd1);
      checkOutput("arm_nostop", {63'b0, stop_pulse}, 64'd0);
      checkOutput("arm_noerr", {63'b0, err_pulse}, 64'd0);
      @(negedge clk);
      checkOutput("arm_low", {63'b0, arm_pulse}, 64'd0);
      finishEcho(8'h41);
      checkOutput("arm_count", 64'(armCount - armSnap), 64'd1);
      checkOutput("arm_other", 64'(stopCount - stopSnap + cfgCount - cfgSnap + errCount - errSnap), 64'd0);

      // Rising-edge config with one mask byte set
      snapCounts();
      for (int i = 0; i < 11; i++) applyStimulus(rCmd[i]);
      checkOutput("r_cfg_valid", {63'b0, cfg_valid}, 64'd1);
      checkOutput("r_edge", {63'b0, trig_edge}, 64'd1);
      checkOutput("r_value", {24'b0, trig_value}, 64'd0);
      checkOutput("r_mask", {24'b0, trig_mask}, 64'h00_0040_0000_00);
      @(negedge clk);
      checkOutput("r_cfg_low", {63'b0, cfg_valid}, 64'd0);
      finishEcho(8'h52);
      checkOutput("r_cfg_count", 64'(cfgCount - cfgSnap), 64'd1);
      checkOutput("r_err_count", 64'(errCount - errSnap), 64'd0);

      // Status query with the transmitter stalled for 5 cycles
      scope_armed = 1'b1;
      snapCounts();
      applyStimulus(8'h3F);
      for (int i = 0; i < 5; i++) begin
         checkOutput("q_valid", {63'b0, tx_valid}, 64'd1);
         checkOutput("q_data", {56'b0, tx_data}, 64'h07);
         @(negedge clk);
      end
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      checkOutput("q_done", {63'b0, tx_valid}, 64'd0);
      checkOutput("q_tx_count", 64'(txCount - txSnap), 64'd1);

      // A byte arriving while a reply is pending is dropped with an error
      snapCounts();
      applyStimulus(8'h3F);
      applyStimulus(8'h41);
      checkOutput("drop_err", {63'b0, err_pulse}, 64'd1);
      checkOutput("drop_noarm", {63'b0, arm_pulse}, 64'd0);
      checkOutput("drop_txv", {63'b0, tx_valid}, 64'd1);
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      @(negedge clk);
      checkOutput("drop_arm_count", 64'(armCount - armSnap), 64'd0);

      // Falling-edge command abandoned after 9 payload bytes
      snapCounts();
      applyStimulus(8'h46);
      for (int i = 0; i < 9; i++) applyStimulus(8'h11 + 8'(i));
      repeat (60) @(negedge clk);
      checkOutput("to_err_count", 64'(errCount - errSnap), 64'd1);
      checkOutput("to_cfg_count", 64'(cfgCount - cfgSnap), 64'd0);
      checkOutput("to_edge", {63'b0, trig_edge}, 64'd1);
      checkOutput("to_value", {24'b0, trig_value}, 64'd0);
      checkOutput("to_mask", {24'b0, trig_mask}, 64'h00_0040_0000_00);
      checkOutput("to_txv", {63'b0, tx_valid}, 64'd0);
      applyStimulus(8'h41);
      checkOutput("to_rearm", {63'b0, arm_pulse}, 64'd1);
      @(negedge clk);
      finishEcho(8'h41);

      // Unknown opcode: only an error strobe
      snapCounts();
      applyStimulus(8'h99);
      checkOutput("bad_err", {63'b0, err_pulse}, 64'd1);
      checkOutput("bad_arm", {63'b0, arm_pulse}, 64'd0);
      checkOutput("bad_stop", {63'b0, stop_pulse}, 64'd0);
      checkOutput("bad_cfg", {63'b0, cfg_valid}, 64'd0);
      checkOutput("bad_txv", {63'b0, tx_valid}, 64'd0);
      checkOutput("bad_mask", {24'b0, trig_mask}, 64'h00_0040_0000_00);

      // Stop, acknowledged by echo when enabled
      applyStimulus(8'h53);
      checkOutput("stop_high", {63'b0, stop_pulse}, 64'd1);
      @(negedge clk);
      checkOutput("stop_low", {63'b0, stop_pulse}, 64'd0);
      finishEcho(8'h53);

      // Slow falling-edge command: 40 idle cycles between bytes stays
      // below the timeout, so it must commit
      snapCounts();
      for (int i = 0; i < 11; i++) begin
         applyStimulus(fSlow[i]);
         if (i != 10) repeat (40) @(negedge clk);
      end
      checkOutput("slow_cfg", {63'b0, cfg_valid}, 64'd1);
      checkOutput("slow_edge", {63'b0, trig_edge}, 64'd0);
      checkOutput("slow_value", {24'b0, trig_value}, 64'h05_0403_0201);
      checkOutput("slow_mask", {24'b0, trig_mask}, 64'h0F_00FF_00FF);
      checkOutput("slow_err_count", 64'(errCount - errSnap), 64'd0);
      @(negedge clk);
      finishEcho(8'h46);

      // Reset after the 5th payload byte, then a fresh command
      applyStimulus(8'h52);
      for (int i = 0; i < 5; i++) applyStimulus(8'h77);
      rst_n = 1'b0;
      @(negedge clk);
      checkResetOutputs("midrst");
      rst_n = 1'b1;
      @(negedge clk);
      snapCounts();
      for (int i = 0; i < 11; i++) applyStimulus(rFresh[i]);
      checkOutput("fresh_cfg", {63'b0, cfg_valid}, 64'd1);
      checkOutput("fresh_edge", {63'b0, trig_edge}, 64'd1);
      checkOutput("fresh_value", {24'b0, trig_value}, 64'hEE_DDCC_BBAA);
      checkOutput("fresh_mask", {24'b0, trig_mask}, 64'h55_4433_2211);
      @(negedge clk);
      finishEcho(8'h52);
      checkOutput("fresh_cfg_count", 64'(cfgCount - cfgSnap), 64'd1);
      checkOutput("fresh_err_count", 64'(errCount - errSnap), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
